// File: rtl/mul_seq_ctrl_if.sv
// rtl/mul_seq_ctrl_if.sv - request/result and multiplier-side signals of mul_seq_ctrl
interface mul_seq_ctrl_if;
    logic       start;
    logic [7:0] operand1;
    logic [7:0] operand2;
    logic [7:0] mul_a;
    logic [7:0] mul_b;
    logic [7:0] mul_result;
    logic [7:0] result;
    logic       done;
    logic       busy;

    modport master (
        output start, operand1, operand2, mul_result,
        input  mul_a, mul_b, result, done, busy
    );

    modport slave (
        input  start, operand1, operand2, mul_result,
        output mul_a, mul_b, result, done, busy
    );
endinterface

// File: rtl/mul_seq_ctrl.sv
// rtl/mul_seq_ctrl.sv - operand hold / settle wait / product capture for an 8-bit array multiplier
// Optional feature: MUL_SEQ_ZERO_BYPASS_EN (zero operand skips the settle wait).
module mul_seq_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic          clk,
    input  logic          reset,
    mul_seq_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

    state_t     state;
    logic [3:0] cnt;
    logic [7:0] mul_a_q;
    logic [7:0] mul_b_q;
    logic [7:0] result_q;
    logic       done_q;
    logic       busy_q;
    logic       zero_hit;

`ifdef MUL_SEQ_ZERO_BYPASS_EN
    // A zero operand makes the product known immediately, so the settle wait is skipped.
    assign zero_hit = (bus.operand1 == 8'd0) || (bus.operand2 == 8'd0);
`else
    assign zero_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= ST_IDLE;
            cnt      <= 4'd0;
            mul_a_q  <= 8'd0;
            mul_b_q  <= 8'd0;
            result_q <= 8'd0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        mul_a_q <= bus.operand1;
                        mul_b_q <= bus.operand2;
                        if (zero_hit) begin
                            result_q <= 8'd0;
                            done_q   <= 1'b1;
                            busy_q   <= 1'b0;
                            state    <= ST_DONE;
                        end else begin
                            cnt    <= CNT_INIT;
                            busy_q <= 1'b1;
                            state  <= ST_SETTLE;
                        end
                    end else begin
                        busy_q <= 1'b0;
                        state  <= ST_IDLE;
                    end
                end
                ST_SETTLE: begin
                    // Operands stay frozen and START is ignored until the product is sampled.
                    if (cnt == 4'd0) begin
                        result_q <= bus.mul_result;
                        done_q   <= 1'b1;
                        busy_q   <= 1'b0;
                        state    <= ST_DONE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: begin
                    busy_q <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.mul_a  = mul_a_q;
    assign bus.mul_b  = mul_b_q;
    assign bus.result = result_q;
    assign bus.done   = done_q;
    assign bus.busy   = busy_q;
endmodule

// File: tb/tb_mul_seq_ctrl.sv
// tb/tb_mul_seq_ctrl.sv - scoreboard bench for mul_seq_ctrl with a slow-settling multiplier model
module tb_mul_seq_ctrl;
    localparam int S = 2;

`ifdef MUL_SEQ_ZERO_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    typedef struct {
        logic       done;
        logic       busy;
        logic [7:0] result;
        logic [7:0] mul_a;
        logic [7:0] mul_b;
    } exp_t;

    logic clk;
    logic reset;
    mul_seq_ctrl_if bus ();

    mul_seq_ctrl #(.SETTLE_CYCLES(S)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int checks   = 0;
    int failures = 0;
    exp_t exp_q[$];

    // Timeline model: an accepted operation at edge k finishes at done_edge.
    int         stim_edge = 0;
    int         next_ok   = 0;
    int         done_edge = 0;
    bit         active    = 1'b0;
    logic [7:0] m_a   = 8'd0;
    logic [7:0] m_b   = 8'd0;
    logic [7:0] m_prd = 8'd0;
    logic [7:0] m_res = 8'd0;

    // Multiplier model: output is wrong until its inputs have been stable long enough.
    logic [7:0] prev_a = 8'd0;
    logic [7:0] prev_b = 8'd0;
    int         age    = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) begin
        int p;
        if (bus.mul_a !== prev_a || bus.mul_b !== prev_b) age = 0;
        else if (age < 1000) age = age + 1;
        prev_a = bus.mul_a;
        prev_b = bus.mul_b;
        p = (int'(bus.mul_a) * int'(bus.mul_b)) % 256;
        bus.mul_result = (age >= S - 1) ? 8'(p) : ~8'(p);
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
        checks = checks + 1;
        if (act !== req) begin
            failures = failures + 1;
            $display("FAIL %s t=%0t actual=%0d required=%0d", name, $time, act, req);
        end
    endtask

    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("done",   {7'd0, bus.done}, {7'd0, e.done});
            chk("busy",   {7'd0, bus.busy}, {7'd0, e.busy});
            chk("result", bus.result, e.result);
            chk("mul_a",  bus.mul_a,  e.mul_a);
            chk("mul_b",  bus.mul_b,  e.mul_b);
        end
    end

    task automatic drive(input bit rst_n, input bit st, input logic [7:0] o1, input logic [7:0] o2);
        exp_t e;
        int   p;
        @(negedge clk);
        reset        = rst_n;
        bus.start    = st;
        bus.operand1 = o1;
        bus.operand2 = o2;
        stim_edge    = stim_edge + 1;
        if (!rst_n) begin
            active  = 1'b0;
            m_a     = 8'd0;
            m_b     = 8'd0;
            m_res   = 8'd0;
            next_ok = stim_edge + 1;
        end else if (st && stim_edge >= next_ok) begin
            m_a   = o1;
            m_b   = o2;
            p     = (int'(o1) * int'(o2)) % 256;
            m_prd = 8'(p);
            done_edge = (BYPASS && (o1 == 8'd0 || o2 == 8'd0)) ? stim_edge : stim_edge + S;
            next_ok   = done_edge + 1;
            active    = 1'b1;
        end
        e.mul_a = m_a;
        e.mul_b = m_b;
        e.busy  = active && (stim_edge < done_edge);
        e.done  = active && (stim_edge == done_edge);
        if (e.done) m_res = m_prd;
        e.result = m_res;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 8'd0, 8'd0);
    endtask

    initial begin
        reset        = 1'b0;
        bus.start    = 1'b0;
        bus.operand1 = 8'd0;
        bus.operand2 = 8'd0;

        drive(1'b0, 1'b0, 8'd0, 8'd0);
        drive(1'b0, 1'b1, 8'd9, 8'd9);
        idle(2);

        drive(1'b1, 1'b1, 8'd5, 8'd3);
        idle(3);

        drive(1'b1, 1'b1, 8'd20, 8'd13);
        drive(1'b1, 1'b1, 8'd99, 8'd13);
        drive(1'b1, 1'b0, 8'd99, 8'd13);
        idle(3);

        for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 8'd2, 8'd3);
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 8'd7, 8'd9);
        idle(2);

        drive(1'b1, 1'b1, 8'd11, 8'd12);
        drive(1'b0, 1'b1, 8'd11, 8'd12);
        idle(4);

        drive(1'b1, 1'b1, 8'd0, 8'd200);
        idle(3);
        drive(1'b1, 1'b1, 8'd255, 8'd0);
        drive(1'b1, 1'b1, 8'd255, 8'd255);
        idle(4);

        for (int i = 0; i < 500; i++) begin
            bit         r;
            bit         st;
            logic [7:0] o1;
            logic [7:0] o2;
            r  = ($urandom_range(0, 99) >= 3);
            st = 1'($urandom_range(0, 1));
            o1 = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
            o2 = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
            drive(r, st, o1, o2);
        end
        idle(S + 3);

        @(posedge clk);
        #2;
        chk("drain", 8'(exp_q.size()), 8'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
